// File: rtl/dsp_bus_scheduler_if.sv
// Requester-side handshake between host request logic and the DSP bus scheduler.
// The scheduler is the slave; host request logic is the master.
interface dsp_bus_scheduler_if;
  logic       reinit;
  logic       wr_req;
  logic [7:0] wr_data;
  logic       wr_ack;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       rd_ack;
  logic       timeout;
  logic       ready;

  modport slave (
    input  reinit, wr_req, wr_data, rd_req,
    output wr_ack, rd_data, rd_ack, timeout, ready
  );

  modport master (
    output reinit, wr_req, wr_data, rd_req,
    input  wr_ack, rd_data, rd_ack, timeout, ready
  );
endinterface

// File: rtl/dsp_bus_scheduler.sv
// Owns the DSP ISA register port: runs the reset engine until accepted, then
// serves round-robin command writes / data reads with bounded status polling.
module dsp_bus_scheduler #(
  parameter logic [15:0] BASE_ADDRESS  = 16'h0000,
  parameter logic [15:0] TIMEOUT_STEPS = 16'd1024
) (
  input  logic                 sys_clock,
  input  logic                 reset_n,
  input  logic                 bus_clock,
  input  logic [15:0]          data_in,
  input  logic                 rst_seq_accepted,
  output logic                 rst_seq_enable,
  output logic                 rst_seq_reset,
  output logic [15:0]          data_out,
  output logic [15:0]          address,
  output logic                 data_dir,
  dsp_bus_scheduler_if.slave   req
);

  localparam logic [15:0] LAST_POLL = TIMEOUT_STEPS - 16'd1;
  localparam logic [15:0] ADDR_RD   = BASE_ADDRESS + 16'h000A;
  localparam logic [15:0] ADDR_WR   = BASE_ADDRESS + 16'h000C;
  localparam logic [15:0] ADDR_RS   = BASE_ADDRESS + 16'h000E;

  typedef enum logic [2:0] {KICK, RWAIT, IDLE, WPOLL, WDATA, RPOLL, RDATA} state_t;

  typedef struct packed {
    state_t      state;
    logic [15:0] cnt;
    logic [7:0]  wr_q;
    logic [7:0]  rd_data;
    logic        ready;
    logic        timeout;
    logic        wr_ack;
    logic        rd_ack;
    logic        last_rd;
  } regs_t;

  localparam regs_t REGS_RST = '{state: KICK, cnt: 16'd0, wr_q: 8'h00, rd_data: 8'h00,
                                 ready: 1'b0, timeout: 1'b0, wr_ack: 1'b0, rd_ack: 1'b0,
                                 last_rd: 1'b1};

  regs_t       r, n;
  logic        poll_last;
  logic [15:0] drv_addr, drv_data;
  logic        drv_dir;
  logic        unused_hi;

  assign poll_last = (r.cnt == LAST_POLL);
  assign unused_hi = ^data_in[15:8];

  always_ff @(posedge sys_clock or negedge reset_n) begin
    if (!reset_n) r <= REGS_RST;
    else          r <= n;
  end

  // Acks are one sys_clock wide regardless of bus_clock, so they default low every cycle.
  always_comb begin
    n        = r;
    n.wr_ack = 1'b0;
    n.rd_ack = 1'b0;
    if (bus_clock) begin
      unique case (r.state)
        KICK: begin
          n.state = RWAIT;
          n.cnt   = 16'd0;
        end
        RWAIT: begin
          if (rst_seq_accepted) begin
            n.state = IDLE;
            n.ready = 1'b1;
          end else if (poll_last) begin
            n.state   = KICK;
            n.timeout = 1'b1;
          end else begin
            n.cnt = r.cnt + 16'd1;
          end
        end
        IDLE: begin
          if (req.reinit) begin
            n.state   = KICK;
            n.ready   = 1'b0;
            n.timeout = 1'b0;
          end else if (!(r.wr_ack || r.rd_ack)) begin
            // Tie goes to whichever side was not granted last.
            if (req.wr_req && (!req.rd_req || r.last_rd)) begin
              n.state   = WPOLL;
              n.wr_q    = req.wr_data;
              n.cnt     = 16'd0;
              n.last_rd = 1'b0;
            end else if (req.rd_req) begin
              n.state   = RPOLL;
              n.cnt     = 16'd0;
              n.last_rd = 1'b1;
            end
          end
        end
        WPOLL: begin
          if (!data_in[7]) begin
            n.state = WDATA;
          end else if (poll_last) begin
            n.state   = IDLE;
            n.wr_ack  = 1'b1;
            n.timeout = 1'b1;
          end else begin
            n.cnt = r.cnt + 16'd1;
          end
        end
        WDATA: begin
          n.state   = IDLE;
          n.wr_ack  = 1'b1;
          n.timeout = 1'b0;
        end
        RPOLL: begin
          if (data_in[7]) begin
            n.state = RDATA;
          end else if (poll_last) begin
            n.state   = IDLE;
            n.rd_ack  = 1'b1;
            n.timeout = 1'b1;
            n.rd_data = 8'h00;
          end else begin
            n.cnt = r.cnt + 16'd1;
          end
        end
        RDATA: begin
          n.state   = IDLE;
          n.rd_data = data_in[7:0];
          n.rd_ack  = 1'b1;
          n.timeout = 1'b0;
        end
        default: n.state = KICK;
      endcase
    end
  end

  always_comb begin
    rst_seq_enable = (r.state == KICK) || (r.state == RWAIT);
    rst_seq_reset  = (r.state == KICK);
    drv_addr       = ADDR_RS;
    drv_data       = 16'h0000;
    drv_dir        = 1'b0;
    case (r.state)
      WPOLL:   drv_addr = ADDR_WR;
      WDATA: begin
        drv_addr = ADDR_WR;
        drv_data = {8'h00, r.wr_q};
        drv_dir  = 1'b1;
      end
      RDATA:   drv_addr = ADDR_RD;
      default: ;
    endcase
  end

  // The reset engine owns the bus while it is enabled.
  assign address  = rst_seq_enable ? {16{1'bz}} : drv_addr;
  assign data_out = rst_seq_enable ? {16{1'bz}} : drv_data;
  assign data_dir = rst_seq_enable ? 1'bz       : drv_dir;

  assign req.wr_ack  = r.wr_ack;
  assign req.rd_ack  = r.rd_ack;
  assign req.rd_data = r.rd_data;
  assign req.timeout = r.timeout;
  assign req.ready   = r.ready;

endmodule

// File: tb/tb_dsp_bus_scheduler.sv
// Directed bench for dsp_bus_scheduler: a transaction-level model checked every
// cycle, plus hand-computed expectations along each scenario.
module tb_dsp_bus_scheduler;
  localparam int TO = 4;

  logic        sys_clock = 1'b0;
  logic        reset_n   = 1'b0;
  logic        bus_clock = 1'b1;
  logic        rst_seq_accepted = 1'b0;
  logic [15:0] din_val = 16'h0000;
  logic        dsp_mode = 1'b0;
  logic [15:0] data_in;
  logic        rst_seq_enable, rst_seq_reset;
  wire  [15:0] data_out, address;
  wire         data_dir;

  dsp_bus_scheduler_if rif ();

  dsp_bus_scheduler #(.BASE_ADDRESS(16'h0000), .TIMEOUT_STEPS(16'(TO))) dut (
    .sys_clock(sys_clock), .reset_n(reset_n), .bus_clock(bus_clock), .data_in(data_in),
    .rst_seq_accepted(rst_seq_accepted), .rst_seq_enable(rst_seq_enable),
    .rst_seq_reset(rst_seq_reset), .data_out(data_out), .address(address),
    .data_dir(data_dir), .req(rif)
  );

  always #5 sys_clock = ~sys_clock;

  // Simple DSP responder: write port always free, read buffer always full.
  assign data_in = !dsp_mode ? din_val :
                   (address == 16'h000C) ? 16'h0000 :
                   (address == 16'h000E) ? 16'h0080 : 16'h005A;

  int n_vec = 0, n_err = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: reset engine phase + job kind / data phase + remaining poll budget.
  bit         m_inrst = 1, m_kick = 1, m_data_ph = 0, m_last_rd = 1;
  int         m_job = 0, m_left = 0;
  bit         m_ready = 0, m_to = 0, m_wack = 0, m_rack = 0;
  logic [7:0] m_wq = 8'h00, m_rdat = 8'h00;

  always @(posedge sys_clock or negedge reset_n) begin
    bit ack_was, go;
    if (!reset_n) begin
      m_inrst = 1; m_kick = 1; m_job = 0; m_data_ph = 0; m_last_rd = 1; m_left = 0;
      m_ready = 0; m_to = 0; m_wack = 0; m_rack = 0; m_wq = 8'h00; m_rdat = 8'h00;
    end else begin
      ack_was = m_wack | m_rack;
      m_wack = 0; m_rack = 0;
      if (bus_clock) begin
        if (m_inrst) begin
          if (m_kick) begin m_kick = 0; m_left = TO; end
          else if (rst_seq_accepted) begin m_inrst = 0; m_ready = 1; m_job = 0; end
          else begin m_left--; if (m_left == 0) begin m_to = 1; m_kick = 1; end end
        end else if (m_job == 0) begin
          if (rif.reinit) begin m_inrst = 1; m_kick = 1; m_ready = 0; m_to = 0; end
          else if (!ack_was && (rif.wr_req || rif.rd_req)) begin
            if (rif.wr_req && (!rif.rd_req || m_last_rd)) begin
              m_job = 1; m_wq = rif.wr_data; m_last_rd = 0;
            end else begin
              m_job = 2; m_last_rd = 1;
            end
            m_data_ph = 0; m_left = TO;
          end
        end else if (m_data_ph) begin
          if (m_job == 1) m_wack = 1;
          else begin m_rack = 1; m_rdat = data_in[7:0]; end
          m_to = 0; m_job = 0;
        end else begin
          go = (m_job == 1) ? !data_in[7] : data_in[7];
          if (go) m_data_ph = 1;
          else begin
            m_left--;
            if (m_left == 0) begin
              if (m_job == 1) m_wack = 1;
              else begin m_rack = 1; m_rdat = 8'h00; end
              m_to = 1; m_job = 0;
            end
          end
        end
      end
    end
  end

  always @(negedge sys_clock) begin
    logic [15:0] ea, ed;
    if (cmp_on) begin
      chk("m.enable", rst_seq_enable, m_inrst);
      chk("m.reset", rst_seq_reset, m_inrst && m_kick);
      chk("m.ready", rif.ready, m_ready);
      chk("m.timeout", rif.timeout, m_to);
      chk("m.wr_ack", rif.wr_ack, m_wack);
      chk("m.rd_ack", rif.rd_ack, m_rack);
      chk("m.rd_data", rif.rd_data, m_rdat);
      if (!m_inrst) begin
        ea = (m_job == 1) ? 16'h000C : (m_job == 2 && m_data_ph) ? 16'h000A : 16'h000E;
        ed = (m_job == 1 && m_data_ph) ? {8'h00, m_wq} : 16'h0000;
        chk("m.address", address, ea);
        chk("m.data_out", data_out, ed);
        chk("m.data_dir", data_dir, m_job == 1 && m_data_ph);
      end
    end
  end

  task automatic step();
    @(posedge sys_clock);
    #3;
  endtask

  initial begin
    logic [7:0] ord;
    int nack, c0c, cdir;
    rif.reinit = 0; rif.wr_req = 0; rif.wr_data = 8'h00; rif.rd_req = 0;
    step(); step();
    cmp_on = 1;
    chk("rst.enable", rst_seq_enable, 1); chk("rst.reset", rst_seq_reset, 1);
    chk("rst.ready", rif.ready, 0); chk("rst.rd_data", rif.rd_data, 8'h00);
    reset_n = 1;
    #1;
    chk("rel.timeout", rif.timeout, 0); chk("rel.wr_ack", rif.wr_ack, 0);

    // Reset engine: accepted only after 5 steps, so the 4-step wait times out once.
    step(); chk("kick1.reset", rst_seq_reset, 0); chk("kick1.enable", rst_seq_enable, 1);
    step(); step(); step(); chk("rwait.timeout", rif.timeout, 0);
    step(); chk("rwait.to_kick", rst_seq_reset, 1); chk("rwait.sticky", rif.timeout, 1);
    rst_seq_accepted = 1;
    step(); chk("kick2.reset", rst_seq_reset, 0);
    step(); chk("step7.ready", rif.ready, 1); chk("step7.enable", rst_seq_enable, 0);
    chk("idle.addr", address, 16'h000E); chk("idle.sticky", rif.timeout, 1);
    rst_seq_accepted = 0;

    // Single write, data_in idle.
    rif.wr_req = 1; rif.wr_data = 8'hE1; din_val = 16'h0000;
    step(); chk("w.poll_addr", address, 16'h000C); chk("w.poll_dir", data_dir, 0);
    rif.wr_data = 8'h55;
    step(); chk("w.data_addr", address, 16'h000C); chk("w.data_out", data_out, 16'h00E1);
    chk("w.data_dir", data_dir, 1);
    step(); chk("w.ack", rif.wr_ack, 1); chk("w.to", rif.timeout, 0); chk("w.dir_off", data_dir, 0);
    step(); chk("w.ack_1cyc", rif.wr_ack, 0); chk("w.no_regrant", address, 16'h000E);
    rif.wr_req = 0;
    step();

    // Read: status bit 7 appears on the third poll.
    rif.rd_req = 1; din_val = 16'h0000;
    step(); step(); step();
    din_val = 16'h0080;
    step(); chk("r.data_addr", address, 16'h000A);
    din_val = 16'h00AA;
    step(); chk("r.ack", rif.rd_ack, 1); chk("r.data", rif.rd_data, 8'hAA); chk("r.to", rif.timeout, 0);
    step(); chk("r.ack_1cyc", rif.rd_ack, 0);
    rif.rd_req = 0;
    step();

    // Both held: grants must alternate starting with write.
    dsp_mode = 1; rif.wr_data = 8'h77; rif.wr_req = 1; rif.rd_req = 1;
    ord = 8'h00; nack = 0;
    for (int k = 0; k < 40 && nack < 4; k++) begin
      step();
      if (rif.wr_ack) begin ord = {ord[5:0], 2'b01}; nack++; end
      if (rif.rd_ack) begin ord = {ord[5:0], 2'b10}; nack++; end
    end
    rif.wr_req = 0; rif.rd_req = 0;
    chk("rr.acks", nack, 4); chk("rr.order", ord, 8'h66); chk("rr.rd_data", rif.rd_data, 8'h5A);
    dsp_mode = 0;
    step(); step(); chk("rr.idle", address, 16'h000E);

    // Write timeout: port never free.
    din_val = 16'h0080; rif.wr_data = 8'h99; rif.wr_req = 1;
    step();
    c0c = 0; cdir = 0;
    for (int k = 0; k < 12; k++) begin
      if (rif.wr_ack) break;
      if (address == 16'h000C) c0c++;
      if (data_dir) cdir++;
      step();
    end
    chk("wto.polls", c0c, TO); chk("wto.dir", cdir, 0);
    chk("wto.ack", rif.wr_ack, 1); chk("wto.flag", rif.timeout, 1);
    step(); rif.wr_req = 0;

    // Read timeout: buffer never fills, rd_data forced to zero.
    din_val = 16'h0000; rif.rd_req = 1;
    nack = 0;
    for (int k = 0; k < 12 && nack == 0; k++) begin step(); if (rif.rd_ack) nack = 1; end
    chk("rto.ack", nack, 1); chk("rto.data", rif.rd_data, 8'h00); chk("rto.flag", rif.timeout, 1);
    step(); rif.rd_req = 0;

    // bus_clock low freezes the FSM; ack still lasts one sys_clock.
    din_val = 16'h0080; rif.wr_data = 8'h3C; rif.wr_req = 1;
    step(); bus_clock = 0;
    step(); step(); step(); chk("hold.addr", address, 16'h000C); chk("hold.dir", data_dir, 0);
    din_val = 16'h0000; bus_clock = 1;
    step(); chk("hold.data", data_out, 16'h003C); chk("hold.wdir", data_dir, 1);
    step(); chk("hold.ack", rif.wr_ack, 1); bus_clock = 0;
    step(); chk("hold.ack_1cyc", rif.wr_ack, 0);
    rif.wr_req = 0; bus_clock = 1;
    step();

    // reinit during RPOLL: read finishes first, then the reset engine reruns.
    rif.rd_req = 1; din_val = 16'h0000;
    step(); rif.reinit = 1;
    step(); din_val = 16'h0080;
    step(); din_val = 16'h0033;
    step(); chk("ri.ack", rif.rd_ack, 1); chk("ri.data", rif.rd_data, 8'h33); chk("ri.ready", rif.ready, 1);
    rif.rd_req = 0;
    step(); chk("ri.kick_en", rst_seq_enable, 1); chk("ri.kick_rst", rst_seq_reset, 1);
    chk("ri.ready0", rif.ready, 0);
    rif.reinit = 0;
    step(); chk("ri.rwait_rst", rst_seq_reset, 0); chk("ri.rwait_en", rst_seq_enable, 1);
    rst_seq_accepted = 1;
    step(); chk("ri.ready1", rif.ready, 1); chk("ri.to", rif.timeout, 0);
    rst_seq_accepted = 0;

    // Reset mid-transaction: back to reset values, no ack.
    din_val = 16'h0080; rif.wr_req = 1;
    step(); step();
    reset_n = 0; #1;
    chk("mr.enable", rst_seq_enable, 1); chk("mr.reset", rst_seq_reset, 1);
    chk("mr.ready", rif.ready, 0); chk("mr.wr_ack", rif.wr_ack, 0);
    rif.wr_req = 0;
    step(); step();
    chk("mr.hold_ack", rif.wr_ack, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dsp_bus_scheduler.md
# dsp_bus_scheduler

Owns the DSP's ISA-side register port and decides who drives it. After reset it runs the reset engine (`Reset_Sequence`) until the DSP has accepted the reset. It then serves byte-wide command writes and data reads from two requesters, using round-robin arbitration and polling the DSP status ports with a bounded timeout. It sits between the reset engine / host-side request logic and the shared `data_out`/`address`/`data_dir` bus.

## Interface
- `BASE_ADDRESS`, 16'h0000, DSP I/O base; this block uses ports +0x0A (read data), +0x0C (write cmd/status), +0x0E (read-buffer status).
- `TIMEOUT_STEPS`, 16'd1024, maximum number of bus steps spent in any poll/wait state; legal range 1..65535.

- `sys_clock` in 1: system clock; all flops on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `bus_clock` in 1: bus-step qualifier; the FSM advances only on `sys_clock` edges where `bus_clock`=1.
- `data_in` in 16: read data from the DSP port.
- `rst_seq_accepted` in 1: `accepted` from the reset engine; meaningful only while `rst_seq_enable`=1.
- `rst_seq_enable` out 1: enables the reset engine's bus drivers.
- `rst_seq_reset` out 1: `reset` to the reset engine (active-high).
- `reinit` in 1: level request to re-run the DSP reset.
- `wr_req` in 1, `wr_data` in 8, `wr_ack` out 1: command-write handshake.
- `rd_req` in 1, `rd_data` out 8, `rd_ack` out 1: data-read handshake.
- `timeout` out 1: qualifies `wr_ack`/`rd_ack`; sticky meaning during reset wait, see below.
- `ready` out 1: DSP reset complete and the scheduler is idle-capable.
- `data_out` out 16, `address` out 16, `data_dir` out 1: shared bus; all z while `rst_seq_enable`=1. `data_dir`=1 means write.

## Operation
- States: KICK, RWAIT, IDLE, WPOLL, WDATA, RPOLL, RDATA.
- **KICK:** `rst_seq_enable`=1, `rst_seq_reset`=1. After one step go to RWAIT; clear the poll counter.
- **RWAIT:** `rst_seq_enable`=1, `rst_seq_reset`=0.
  - `rst_seq_accepted`=1 at a step: go to IDLE and set `ready`=1.
  - Timeout: set `timeout` (sticky) and go to KICK.
- **IDLE:** own bus: `address`=BASE+0x0E, `data_dir`=0, `data_out`=0. Priority order at a step:
  1. `reinit`=1: go to KICK and clear `ready`/`timeout`.
  2. Otherwise arbitrate `wr_req`/`rd_req` round-robin. `last_grant` resets to "read", so the first tie goes to write.
  - Requests are ignored in any cycle where `wr_ack` or `rd_ack` is high.
- **Write grant:** latch `wr_data` into `wr_q`, clear the counter, go to WPOLL.
  - **WPOLL:** `address`=BASE+0x0C, `data_dir`=0. `data_in[7]`=0 at a step: go to WDATA.
  - **WDATA:** `address`=BASE+0x0C, `data_out`={8'h00,`wr_q`}, `data_dir`=1 for exactly one step. Then go to IDLE and pulse `wr_ack`.
- **Read grant:** clear the counter, go to RPOLL.
  - **RPOLL:** `address`=BASE+0x0E, `data_dir`=0. `data_in[7]`=1 at a step: go to RDATA.
  - **RDATA:** `address`=BASE+0x0A, `data_dir`=0. At the step edge capture `data_in[7:0]` into `rd_data`, go to IDLE, pulse `rd_ack`.
- **Poll counter:** 16-bit, counts steps in RWAIT/WPOLL/RPOLL only.
  - At a step where the exit condition is false and count==TIMEOUT_STEPS-1, time out.
  - Otherwise count+1. Exactly TIMEOUT_STEPS polls are made; no wrap is possible.
- **Timeout in WPOLL/RPOLL:** go to IDLE, pulse the matching ack with `timeout`=1. On a read timeout `rd_data`=8'h00. A timed-out write is never issued.
- Once granted, a transaction always completes. `reinit` is acted on only in IDLE.
- `wr_data` changes after grant have no effect.

## Timing
- Reset values:
  - FSM in KICK.
  - `rst_seq_enable`=1, `rst_seq_reset`=1.
  - `ready`=0, `wr_ack`=0, `rd_ack`=0, `timeout`=0, `rd_data`=8'h00.
  - `data_out`/`address`/`data_dir` = z.
  - `wr_q`=0, counter=0.
- Bus outputs and the enables decode from state; they change one `sys_clock` after the transition edge.
- `wr_ack`/`rd_ack` are registered, high for exactly one `sys_clock` cycle following the transition into IDLE. `timeout` is valid in that same cycle.
- The requester holds `req` until ack, then drops it on the next edge.
- Best-case latency, in bus steps from the grant edge to ack:
  - Write: 2 (WPOLL→WDATA→IDLE).
  - Read: 2.
- `reset_n` mid-transaction: immediate return to reset values, with no ack.
- `bus_clock` low: all state, counters and outputs hold. Ack pulses still last one `sys_clock` cycle.

## Test plan
- Reset, `bus_clock`=1 always, `rst_seq_accepted` rises after 5 steps: KICK lasts 1 step, `ready`=1 on step 7, bus is z until IDLE, then `address`=BASE+0x0E.
- `wr_req` with `wr_data`=8'hE1, `data_in`=16'h0000: WPOLL, then WDATA drives `address`=BASE+0x0C, `data_out`=16'h00E1, `data_dir`=1 for one step; `wr_ack` is 1 cycle and `timeout`=0.
- `rd_req` with `data_in` bit 7 set on the 3rd poll and `data_in`=16'h00AA in RDATA: `rd_data`=8'hAA and `rd_ack` pulses.
- `wr_req` and `rd_req` both held: grants alternate W, R, W, R; no double grant in the ack cycle.
- TIMEOUT_STEPS=4, `data_in[7]`=1 forever, `wr_req`: exactly 4 WPOLL steps, then `wr_ack`+`timeout`, `data_dir` never 1.
- `reinit` while a read is in RPOLL: the read completes first, then KICK; `ready` drops, and the reset engine is re-enabled with `rst_seq_reset` high for 1 step.
